// File: rtl/pkt_router.sv
// Byte-stream packet router: DD src dest len payload[len] -> one of N_CH output lanes.
// Optional inter-byte timeout compiled in with PKT_ROUTER_TIMEOUT_EN.

module pkt_router_lane #(
   parameter int LANE_ID = 0
) (
   input  logic       out_valid,
   input  logic [3:0] out_ch,
   input  logic [7:0] out_data,
   output logic       lane_valid,
   output logic [7:0] lane_data
);
   logic hit;

   assign hit        = out_valid && (out_ch == 4'(LANE_ID));
   assign lane_valid = hit;
   assign lane_data  = hit ? out_data : 8'h00;
endmodule

module pkt_router #(
   parameter int          N_CH        = 5,
   parameter logic [7:0]  PREFIX      = 8'hDD,
   parameter int          TIMEOUT_CYC = 50000
) (
   input  logic              fpga_clk_48,
   input  logic              rst,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N_CH-1:0]   ready_bus,
   output logic [N_CH*8-1:0] data_bus,
   output logic [N_CH-1:0]   valid_bus,
   output logic [2:0]        my_state,
   output logic [7:0]        my_src,
   output logic [7:0]        my_dest,
   output logic [7:0]        my_len,
   output logic [7:0]        my_cnt,
   output logic [7:0]        drop_cnt
);
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SRC     = 3'd1,
      DEST    = 3'd2,
      LEN     = 3'd3,
      PAYLOAD = 3'd4,
      DROP    = 3'd5
   } state_t;

   state_t      state;
   logic        out_valid;
   logic [7:0]  out_data;
   logic [3:0]  out_ch;
   logic [15:0] rdy_ext;
   logic        xfer;
   logic        pop;
   logic        last_byte;

`ifdef PKT_ROUTER_TIMEOUT_EN
   logic [15:0] to_cnt;
`endif

   // Widen ready to 16 lanes so a 4-bit channel index is always in range.
   always_comb begin
      rdy_ext = '0;
      rdy_ext[N_CH-1:0] = ready_bus;
   end

   // A byte left over from the previous packet must drain before a packet
   // for a different lane may load the output register.
   always_comb begin
      in_ready = 1'b0;
      if (!rst) begin
         if (state == PAYLOAD)
            in_ready = !out_valid || (rdy_ext[out_ch] && (out_ch == my_dest[3:0]));
         else
            in_ready = 1'b1;
      end
   end

   assign xfer      = in_valid && in_ready;
   assign pop       = out_valid && rdy_ext[out_ch];
   assign last_byte = (my_cnt == my_len - 8'd1);
   assign my_state  = state;

   always_ff @(posedge fpga_clk_48) begin
      if (rst) begin
         state     <= IDLE;
         my_src    <= 8'h00;
         my_dest   <= 8'h00;
         my_len    <= 8'h00;
         my_cnt    <= 8'h00;
         drop_cnt  <= 8'h00;
         out_valid <= 1'b0;
         out_data  <= 8'h00;
         out_ch    <= 4'h0;
`ifdef PKT_ROUTER_TIMEOUT_EN
         to_cnt    <= 16'h0000;
`endif
      end else begin
         if (pop)
            out_valid <= 1'b0;

         case (state)
            IDLE: begin
               if (xfer && in_data == PREFIX)
                  state <= SRC;
            end
            SRC: begin
               if (xfer) begin
                  my_src <= in_data;
                  state  <= DEST;
               end
            end
            DEST: begin
               if (xfer) begin
                  my_dest <= in_data;
                  state   <= LEN;
               end
            end
            LEN: begin
               if (xfer) begin
                  my_len <= in_data;
                  my_cnt <= 8'h00;
                  if (in_data == 8'h00)
                     state <= IDLE;
                  else if (my_dest < 8'(N_CH))
                     state <= PAYLOAD;
                  else
                     state <= DROP;
               end
            end
            PAYLOAD: begin
               if (xfer) begin
                  out_valid <= 1'b1;
                  out_data  <= in_data;
                  out_ch    <= my_dest[3:0];
                  my_cnt    <= my_cnt + 8'd1;
                  if (last_byte)
                     state <= IDLE;
               end
            end
            DROP: begin
               if (xfer) begin
                  my_cnt <= my_cnt + 8'd1;
                  if (last_byte) begin
                     state <= IDLE;
                     if (drop_cnt != 8'hFF)
                        drop_cnt <= drop_cnt + 8'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase

`ifdef PKT_ROUTER_TIMEOUT_EN
         // Stalled mid-packet: abandon it, but leave the output register alone.
         if (state == IDLE || xfer)
            to_cnt <= 16'h0000;
         else if (to_cnt == 16'(TIMEOUT_CYC - 1)) begin
            to_cnt <= 16'h0000;
            state  <= IDLE;
            if (drop_cnt != 8'hFF)
               drop_cnt <= drop_cnt + 8'd1;
         end else
            to_cnt <= to_cnt + 16'd1;
`endif
      end
   end

   for (genvar k = 0; k < N_CH; k++) begin : g_lane
      pkt_router_lane #(.LANE_ID(k)) u_lane (
         .out_valid (out_valid),
         .out_ch    (out_ch),
         .out_data  (out_data),
         .lane_valid(valid_bus[k]),
         .lane_data (data_bus[8*k +: 8])
      );
   end
endmodule

// File: tb/tb_pkt_router.sv
// Directed self-checking bench for pkt_router (N_CH=5, TIMEOUT_CYC=100).

module tb_pkt_router;
   localparam int N_CH = 5;

   logic            fpga_clk_48 = 1'b0;
   logic            rst;
   logic [7:0]      in_data;
   logic            in_valid;
   logic            in_ready;
   logic [N_CH-1:0] ready_bus;
   logic [N_CH*8-1:0] data_bus;
   logic [N_CH-1:0] valid_bus;
   logic [2:0]      my_state;
   logic [7:0]      my_src, my_dest, my_len, my_cnt, drop_cnt;

   int checks   = 0;
   int failures = 0;
   logic [11:0] got_q[$];
   logic [11:0] exp_q[$];
   logic [7:0]  seq[$];

   pkt_router #(.N_CH(N_CH), .PREFIX(8'hDD), .TIMEOUT_CYC(100)) dut (
      .fpga_clk_48(fpga_clk_48),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .ready_bus  (ready_bus),
      .data_bus   (data_bus),
      .valid_bus  (valid_bus),
      .my_state   (my_state),
      .my_src     (my_src),
      .my_dest    (my_dest),
      .my_len     (my_len),
      .my_cnt     (my_cnt),
      .drop_cnt   (drop_cnt)
   );

   always #5 fpga_clk_48 = ~fpga_clk_48;

   // Sink-side monitor: a byte is taken at the coming posedge when valid && ready.
   always @(negedge fpga_clk_48) begin
      #2;
      for (int k = 0; k < N_CH; k++)
         if (valid_bus[k] && ready_bus[k])
            got_q.push_back({4'(k), data_bus[8*k +: 8]});
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      int n;
      n = 0;
      in_data  = b;
      in_valid = 1'b1;
      #1;
      while (!in_ready && n < 200) begin
         @(negedge fpga_clk_48);
         #1;
         n++;
      end
      if (!in_ready) chk("send_timeout", {63'd0, in_ready}, 64'd1);
      @(negedge fpga_clk_48);
      in_valid = 1'b0;
   endtask

   task automatic send_seq();
      foreach (seq[i]) send(seq[i]);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge fpga_clk_48);
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
      foreach (exp_q[i])
         chk(tag, (i < got_q.size()) ? 64'(got_q[i]) : 64'hFFF, 64'(exp_q[i]));
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      logic stable;
      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; ready_bus = '1;
      idle(2);
      #1;
      chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
      chk("rst_state", 64'(my_state), 64'd0);
      chk("rst_valid", 64'(valid_bus), 64'd0);
      chk("rst_data", 64'(data_bus), 64'd0);
      chk("rst_drop", 64'(drop_cnt), 64'd0);
      rst = 1'b0;
      idle(1);

      // Basic route to lane 2
      seq = '{8'hDD, 8'h01, 8'h02, 8'h06, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      send_seq();
      #1;
      chk("lat_valid", 64'(valid_bus), 64'h04);
      chk("lat_data", 64'(data_bus), 64'h00_00_06_00_00);
      idle(3);
      exp_q = '{12'h201, 12'h202, 12'h203, 12'h204, 12'h205, 12'h206};
      check_outputs("route2");
      chk("route2_state", 64'(my_state), 64'd0);
      chk("route2_drop", 64'(drop_cnt), 64'd0);
      chk("route2_src", 64'(my_src), 64'h01);
      chk("route2_cnt", 64'(my_cnt), 64'h06);

      // Destination out of range is dropped
      seq = '{8'hDD, 8'h01, 8'h07, 8'h03, 8'hAA, 8'hBB, 8'hCC};
      send_seq();
      idle(3);
      check_outputs("drop");
      chk("drop_cnt1", 64'(drop_cnt), 64'd1);
      chk("drop_state", 64'(my_state), 64'd0);

      // Junk before prefix and a zero-length packet
      seq = '{8'h55, 8'hDD, 8'h03, 8'h00, 8'h00};
      send_seq();
      #1;
      chk("len0_state", 64'(my_state), 64'd0);
      chk("len0_len", 64'(my_len), 64'd0);
      chk("len0_src", 64'(my_src), 64'h03);
      seq = '{8'h04, 8'h00};
      send_seq();
      idle(3);
      chk("len0_state2", 64'(my_state), 64'd0);
      check_outputs("len0");

      // Back-pressure on lane 1
      ready_bus = 5'b11101;
      seq = '{8'hDD, 8'h01, 8'h01, 8'h02, 8'h11};
      send_seq();
      fork
         send(8'h22);
         begin
            stable = 1'b1;
            for (int i = 0; i < 10; i++) begin
               #1;
               if (valid_bus !== 5'b00010 || data_bus !== 40'h00_00_00_11_00 || in_ready !== 1'b0)
                  stable = 1'b0;
               @(negedge fpga_clk_48);
            end
            ready_bus[1] = 1'b1;
         end
      join
      chk("hold_stable", {63'd0, stable}, 64'd1);
      idle(3);
      exp_q = '{12'h111, 12'h122};
      check_outputs("bp");

      // Reset mid-packet with a byte still pending in the output register
      seq = '{8'hDD, 8'h01, 8'h03, 8'h06, 8'hA1, 8'hA2, 8'hA3};
      send_seq();
      ready_bus = '0;
      rst = 1'b1;
      #1;
      chk("midrst_in_ready", {63'd0, in_ready}, 64'd0);
      @(negedge fpga_clk_48);
      rst = 1'b0;
      #1;
      chk("midrst_state", 64'(my_state), 64'd0);
      chk("midrst_status", {my_src, my_dest, my_len, my_cnt, drop_cnt}, 64'd0);
      chk("midrst_valid", 64'(valid_bus), 64'd0);
      chk("midrst_data", 64'(data_bus), 64'd0);
      ready_bus = '1;
      idle(3);
      exp_q = '{12'h3A1, 12'h3A2};
      check_outputs("midrst");
      seq = '{8'hDD, 8'h02, 8'h04, 8'h01, 8'h5A};
      send_seq();
      idle(3);
      exp_q = '{12'h45A};
      check_outputs("after_rst");

`ifdef PKT_ROUTER_TIMEOUT_EN
      seq = '{8'hDD, 8'h01, 8'h02, 8'h05, 8'h01};
      send_seq();
      idle(102);
      chk("to_state", 64'(my_state), 64'd0);
      chk("to_drop", 64'(drop_cnt), 64'd1);
      seq = '{8'hDD, 8'h01, 8'h02, 8'h01, 8'h09};
      send_seq();
      idle(3);
      exp_q = '{12'h201, 12'h209};
      check_outputs("timeout");
`endif

      // drop_cnt saturates at FF
      for (int i = 0; i < 255; i++) begin
         seq = '{8'hDD, 8'h01, 8'h07, 8'h01, 8'h00};
         send_seq();
      end
      idle(1);
      chk("sat_ff", 64'(drop_cnt), 64'hFF);
      send_seq();
      idle(1);
      chk("sat_hold", 64'(drop_cnt), 64'hFF);
      check_outputs("sat");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
